// File: rtl/mvm_result_drain.sv
// Captures one K-word MVM result burst into a local buffer, tracks its signed
// maximum, and replays the words downstream under a valid/ready handshake.
module mvm_result_drain #(
   parameter int K   = 32,
   parameter int W   = 16,
   parameter int LAT = 2
) (
   input  logic                   i_clk,
   input  logic                   i_reset,
   input  logic                   i_mvm_done,
   input  logic signed [W-1:0]    i_mvm_data,
   output logic                   o_out_valid,
   input  logic                   i_out_ready,
   output logic signed [W-1:0]    o_out_data,
   output logic [$clog2(K)-1:0]   o_out_index,
   output logic                   o_out_last,
   output logic signed [W-1:0]    o_max_data,
   output logic [$clog2(K)-1:0]   o_max_index,
   output logic                   o_max_valid,
   output logic                   o_busy,
   output logic                   o_overrun
);

   localparam int IW        = $clog2(K);
   localparam int CW        = (LAT > 2) ? $clog2(LAT) : 1;
   localparam int WAIT_LOAD = (LAT > 2) ? (LAT - 2) : 0;

   typedef enum logic [1:0] {
      S_IDLE    = 2'd0,
      S_WAIT    = 2'd1,
      S_CAPTURE = 2'd2,
      S_DRAIN   = 2'd3
   } state_t;

   state_t              r_state;
   state_t              w_state_nxt;

   logic [CW-1:0]       r_wait_cnt;
   logic [IW-1:0]       r_cap_idx;
   logic [IW-1:0]       r_out_index;
   logic [IW-1:0]       r_max_index;
   logic signed [W-1:0] r_out_data;
   logic signed [W-1:0] r_max_data;
   logic                r_max_valid;
   logic                r_overrun;
   logic signed [W-1:0] r_buf [K];

   logic                w_cap_last;
   logic                w_cap_enter;
   logic                w_xfer;
   logic                w_last_xfer;
   logic                w_new_max;

   assign w_cap_last  = (r_state == S_CAPTURE) && (r_cap_idx == IW'(K - 1));
   assign w_cap_enter = (w_state_nxt == S_CAPTURE) && (r_state != S_CAPTURE);
   assign w_xfer      = (r_state == S_DRAIN) && i_out_ready;
   assign w_last_xfer = w_xfer && (r_out_index == IW'(K - 1));
   // Strict compare keeps the earlier index on ties; slot 0 always seeds the max.
   assign w_new_max   = (r_cap_idx == '0) || (i_mvm_data > r_max_data);

   // State register
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Next-state logic
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_IDLE: begin
            if (i_mvm_done) begin
               w_state_nxt = (LAT == 1) ? S_CAPTURE : S_WAIT;
            end
         end
         S_WAIT: begin
            if (r_wait_cnt == '0) begin
               w_state_nxt = S_CAPTURE;
            end
         end
         S_CAPTURE: begin
            if (w_cap_last) begin
               w_state_nxt = S_DRAIN;
            end
         end
         S_DRAIN: begin
            if (w_last_xfer) begin
               w_state_nxt = S_IDLE;
            end
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   // Output decode
   always_comb begin
      o_out_valid = (r_state == S_DRAIN);
      o_busy      = (r_state != S_IDLE);
      o_out_last  = (r_state == S_DRAIN) && (r_out_index == IW'(K - 1));
   end

   // Control counters and status flags
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_wait_cnt  <= '0;
         r_cap_idx   <= '0;
         r_max_valid <= 1'b0;
         r_overrun   <= 1'b0;
      end else begin
         if ((r_state == S_IDLE) && i_mvm_done) begin
            r_wait_cnt <= CW'(WAIT_LOAD);
         end else if (r_state == S_WAIT) begin
            r_wait_cnt <= r_wait_cnt - CW'(1);
         end

         if (r_state == S_CAPTURE) begin
            r_cap_idx <= r_cap_idx + IW'(1);
         end else begin
            r_cap_idx <= '0;
         end

         if (w_cap_last) begin
            r_max_valid <= 1'b1;
         end else if (w_cap_enter) begin
            r_max_valid <= 1'b0;
         end

         if (i_mvm_done && (r_state != S_IDLE)) begin
            r_overrun <= 1'b1;
         end
      end
   end

   // Result buffer write port
   always_ff @(posedge i_clk) begin
      if (r_state == S_CAPTURE) begin
         r_buf[r_cap_idx] <= i_mvm_data;
      end
   end

   // Running maximum and registered output word
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_max_data  <= '0;
         r_max_index <= '0;
         r_out_data  <= '0;
         r_out_index <= '0;
      end else begin
         if ((r_state == S_CAPTURE) && w_new_max) begin
            r_max_data  <= i_mvm_data;
            r_max_index <= r_cap_idx;
         end

         // buf[0] was written K-1 cycles ago, so it is safe to preload here.
         if (w_cap_last) begin
            r_out_data  <= r_buf[0];
            r_out_index <= '0;
         end else if (w_xfer && !w_last_xfer) begin
            r_out_data  <= r_buf[r_out_index + IW'(1)];
            r_out_index <= r_out_index + IW'(1);
         end
      end
   end

   assign o_out_data  = r_out_data;
   assign o_out_index = r_out_index;
   assign o_max_data  = r_max_data;
   assign o_max_index = r_max_index;
   assign o_max_valid = r_max_valid;
   assign o_overrun   = r_overrun;

endmodule

// File: tb/tb_mvm_result_drain.sv
// Directed bench for mvm_result_drain: K=32/LAT=2 main instance plus two
// small K=4 instances at LAT=1 and LAT=4 for capture-alignment checks.
module tb_mvm_result_drain;

   localparam int K  = 32;
   localparam int W  = 16;
   localparam int KS = 4;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic                 reset, mvm_done, out_ready;
   logic signed [W-1:0]  mvm_data;
   logic                 o_out_valid, o_out_last, o_max_valid, o_busy, o_overrun;
   logic signed [W-1:0]  o_out_data, o_max_data;
   logic [4:0]           o_out_index, o_max_index;

   logic                 d_done, d_ready;
   logic signed [W-1:0]  d_data;
   logic                 u1_valid, u1_last, u1_max_valid, u1_busy, u1_overrun;
   logic signed [W-1:0]  u1_data, u1_max_data;
   logic [1:0]           u1_index, u1_max_index;
   logic                 u4_valid, u4_last, u4_max_valid, u4_busy, u4_overrun;
   logic signed [W-1:0]  u4_data, u4_max_data;
   logic [1:0]           u4_index, u4_max_index;

   mvm_result_drain #(.K(K), .W(W), .LAT(2)) dut (
      .i_clk(clk), .i_reset(reset), .i_mvm_done(mvm_done), .i_mvm_data(mvm_data),
      .o_out_valid(o_out_valid), .i_out_ready(out_ready), .o_out_data(o_out_data),
      .o_out_index(o_out_index), .o_out_last(o_out_last), .o_max_data(o_max_data),
      .o_max_index(o_max_index), .o_max_valid(o_max_valid), .o_busy(o_busy),
      .o_overrun(o_overrun)
   );

   mvm_result_drain #(.K(KS), .W(W), .LAT(1)) u_lat1 (
      .i_clk(clk), .i_reset(reset), .i_mvm_done(d_done), .i_mvm_data(d_data),
      .o_out_valid(u1_valid), .i_out_ready(d_ready), .o_out_data(u1_data),
      .o_out_index(u1_index), .o_out_last(u1_last), .o_max_data(u1_max_data),
      .o_max_index(u1_max_index), .o_max_valid(u1_max_valid), .o_busy(u1_busy),
      .o_overrun(u1_overrun)
   );

   mvm_result_drain #(.K(KS), .W(W), .LAT(4)) u_lat4 (
      .i_clk(clk), .i_reset(reset), .i_mvm_done(d_done), .i_mvm_data(d_data),
      .o_out_valid(u4_valid), .i_out_ready(d_ready), .o_out_data(u4_data),
      .o_out_index(u4_index), .o_out_last(u4_last), .o_max_data(u4_max_data),
      .o_max_index(u4_max_index), .o_max_valid(u4_max_valid), .o_busy(u4_busy),
      .o_overrun(u4_overrun)
   );

   int nvec = 0;
   int nerr = 0;
   logic signed [W-1:0] yv [K];

   task automatic chk(input string tag, input logic signed [31:0] obs,
                      input logic signed [31:0] exp);
      nvec++;
      assert (obs === exp) else begin
         nerr++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Pulse mvm_done, spend one garbage cycle (LAT-1), then feed yv[0..K-1].
   task automatic start_job(input int dup_at);
      out_ready = 1'b1;
      mvm_done  = 1'b1;
      tick();
      mvm_done  = 1'b0;
      mvm_data  = 16'sh7FFF;
      chk("busy_after_done", o_busy, 1);
      tick();
      for (int i = 0; i < K; i++) begin
         mvm_data = yv[i];
         mvm_done = (i == dup_at);
         if (i == 3) chk("max_valid_in_capture", o_max_valid, 0);
         tick();
         mvm_done = 1'b0;
         if (i == dup_at) chk("overrun_next_cycle", o_overrun, 1);
      end
      mvm_data = '0;
   endtask

   task automatic drain(input bit toggle, input int stop_at, output bit stopped);
      int idx = 0;
      int cyc = 0;
      bit rdy;
      stopped = 1'b0;
      while (idx < K && cyc < 4 * K && !stopped) begin
         rdy       = toggle ? (cyc % 2 == 0) : 1'b1;
         out_ready = rdy;
         chk("out_valid", o_out_valid, 1);
         chk("out_data", o_out_data, yv[idx]);
         chk("out_index", o_out_index, idx);
         chk("out_last", o_out_last, (idx == K - 1));
         if (idx == stop_at) begin
            stopped = 1'b1;
         end else begin
            tick();
            if (rdy) idx++;
            cyc++;
         end
      end
      if (!stopped) begin
         chk("drain_words", idx, K);
         chk("drain_cycles", cyc, toggle ? (2 * K - 1) : K);
         chk("valid_after_last", o_out_valid, 0);
         chk("busy_after_last", o_busy, 0);
      end
      out_ready = 1'b1;
   endtask

   initial begin
      bit st;
      reset = 1'b1; mvm_done = 1'b1; mvm_data = '0; out_ready = 1'b1;
      d_done = 1'b0; d_data = '0; d_ready = 1'b1;
      tick();
      tick();
      chk("rst_out_valid", o_out_valid, 0);
      chk("rst_out_data", o_out_data, 0);
      chk("rst_out_index", o_out_index, 0);
      chk("rst_out_last", o_out_last, 0);
      chk("rst_max_data", o_max_data, 0);
      chk("rst_max_index", o_max_index, 0);
      chk("rst_max_valid", o_max_valid, 0);
      chk("rst_busy", o_busy, 0);
      chk("rst_overrun", o_overrun, 0);
      reset = 1'b0; mvm_done = 1'b0;
      tick();
      chk("done_with_reset_ignored", o_busy, 0);

      // Ramp job, ready held high
      for (int i = 0; i < K; i++) yv[i] = W'(i * 3 - 40);
      start_job(-1);
      chk("ramp_max_valid", o_max_valid, 1);
      chk("ramp_max_data", o_max_data, 53);
      chk("ramp_max_index", o_max_index, 31);
      drain(1'b0, -1, st);

      // Same ramp, ready toggling
      start_job(-1);
      drain(1'b1, -1, st);
      chk("max_valid_held_idle", o_max_valid, 1);

      // Tie on the maximum: lower index wins
      for (int i = 0; i < K; i++) yv[i] = -16'sd5;
      yv[7]  = 16'sh7FFF;
      yv[20] = 16'sh7FFF;
      start_job(-1);
      chk("tie_max_valid", o_max_valid, 1);
      chk("tie_max_data", o_max_data, 32767);
      chk("tie_max_index", o_max_index, 7);
      drain(1'b0, -1, st);

      // Dropped mvm_done during capture
      for (int i = 0; i < K; i++) yv[i] = W'(i * 3 - 40);
      chk("overrun_before", o_overrun, 0);
      start_job(10);
      drain(1'b0, -1, st);
      repeat (3) tick();
      chk("no_second_job_busy", o_busy, 0);
      chk("no_second_job_valid", o_out_valid, 0);
      chk("overrun_sticky", o_overrun, 1);

      // Reset mid-drain at word 10, then a clean job
      start_job(-1);
      drain(1'b0, 10, st);
      chk("stopped_at_10", st, 1);
      reset = 1'b1;
      tick();
      reset = 1'b0;
      chk("mid_rst_out_valid", o_out_valid, 0);
      chk("mid_rst_out_data", o_out_data, 0);
      chk("mid_rst_out_index", o_out_index, 0);
      chk("mid_rst_out_last", o_out_last, 0);
      chk("mid_rst_max_data", o_max_data, 0);
      chk("mid_rst_max_index", o_max_index, 0);
      chk("mid_rst_max_valid", o_max_valid, 0);
      chk("mid_rst_busy", o_busy, 0);
      chk("mid_rst_overrun", o_overrun, 0);
      repeat (2) tick();
      chk("post_rst_valid", o_out_valid, 0);
      start_job(-1);
      chk("post_rst_max_data", o_max_data, 53);
      drain(1'b0, -1, st);

      // LAT=1 / LAT=4 alignment: data in cycle j after the pulse is 100+j
      d_done = 1'b1; d_data = 16'sd100;
      tick();
      d_done = 1'b0;
      for (int j = 1; j <= 16; j++) begin
         d_data = W'(100 + j);
         chk("lat1_valid", u1_valid, (j >= 1 + KS) && (j < 1 + 2 * KS));
         if (j >= 1 + KS && j < 1 + 2 * KS) begin
            chk("lat1_data", u1_data, 101 + (j - 1 - KS));
            chk("lat1_index", u1_index, j - 1 - KS);
            chk("lat1_last", u1_last, (j == 2 * KS));
         end
         chk("lat4_valid", u4_valid, (j >= 4 + KS) && (j < 4 + 2 * KS));
         if (j >= 4 + KS && j < 4 + 2 * KS) begin
            chk("lat4_data", u4_data, 104 + (j - 4 - KS));
            chk("lat4_index", u4_index, j - 4 - KS);
            chk("lat4_last", u4_last, (j == 3 + 2 * KS));
         end
         tick();
      end
      chk("lat1_max_data", u1_max_data, 104);
      chk("lat1_max_index", u1_max_index, 3);
      chk("lat1_max_valid", u1_max_valid, 1);
      chk("lat1_idle", u1_busy, 0);
      chk("lat1_overrun", u1_overrun, 0);
      chk("lat4_max_data", u4_max_data, 107);
      chk("lat4_max_index", u4_max_index, 3);
      chk("lat4_max_valid", u4_max_valid, 1);
      chk("lat4_idle", u4_busy, 0);
      chk("lat4_overrun", u4_overrun, 0);

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end

endmodule

// File: doc/mvm_result_drain.md
MVM_RESULT_DRAIN -- requirements
Module: mvm_result_drain

Interface
REQ-001 SHALL have parameter K, default 32, the number of result words per MVM job (power of two, 2..1024).
REQ-002 SHALL have parameter W, default 16, the signed result word width.
REQ-003 SHALL have parameter LAT, default 2, the cycles from the cycle mvm_done is sampled high to the cycle y[0] is valid on mvm_data (LAT >= 1).
REQ-004 SHALL have one clock and a synchronous, active-high reset: clk  input  1  rising-edge clock.
REQ-005 reset  input  1  synchronous active-high reset.
REQ-006 mvm_done  input  1  one-cycle pulse from the upstream MVM marking the start of its result readout.
REQ-007 mvm_data  input  W  signed result stream y[0..K-1], one word per cycle.
REQ-008 out_valid  output  1  output word valid.
REQ-009 out_ready  input  1  downstream accepts the word.
REQ-010 out_data  output  W  signed result word.
REQ-011 out_index  output  log2(K)  index of out_data.
REQ-012 out_last  output  1  high with index K-1.
REQ-013 max_data  output  W  largest signed result of the last job.
REQ-014 max_index  output  log2(K)  index of max_data.
REQ-015 max_valid  output  1  max_data and max_index valid.
REQ-016 busy  output  1  high in any state other than IDLE.
REQ-017 overrun  output  1  sticky: an mvm_done pulse was dropped.

Function
REQ-018 SHALL implement the states IDLE, WAIT, CAPTURE and DRAIN, with a K x W internal buffer.
REQ-019 IDLE: on mvm_done=1, go to CAPTURE if LAT=1, otherwise load a counter with LAT-2 and go to WAIT.
REQ-020 WAIT: decrement the counter each cycle, and go to CAPTURE on the cycle it reads 0.
REQ-021 CAPTURE: write mvm_data to buf[cap_idx] on every cycle for exactly K consecutive cycles (cap_idx 0..K-1), then go to DRAIN.
REQ-022 CAPTURE: y[i] is the mvm_data value on the i-th CAPTURE cycle, counted from 0.
REQ-023 CAPTURE: track the running maximum with a signed compare; on a tie, keep the lower index.
REQ-024 CAPTURE: hold max_valid at 0.
REQ-025 DRAIN: out_valid=1, with registered out_data=buf[rd_idx] and out_index=rd_idx; rd_idx starts at 0.
REQ-026 A transfer occurs on a cycle with out_valid and out_ready both high; rd_idx then increments and the next word appears on the following cycle.
REQ-027 While out_valid=1 and out_ready=0, out_data, out_index and out_last SHALL hold stable.
REQ-028 A transfer with out_last=1 returns the block to IDLE; out_valid is 0 on the next cycle.
REQ-029 With out_ready held high, DRAIN SHALL transfer K words in K consecutive cycles.
REQ-030 max_valid SHALL assert on the first DRAIN cycle and stay high until the next CAPTURE entry or reset.
REQ-031 mvm_done=1 in any state other than IDLE SHALL be ignored and SHALL set overrun on the next cycle; overrun clears only on reset.
REQ-032 out_valid SHALL be 0 outside DRAIN; out_data SHALL never change while out_valid=1 and out_ready=0.
REQ-033 busy SHALL be 1 from the cycle after mvm_done is accepted through the last DRAIN transfer.

Reset
REQ-034 reset=1 SHALL force state IDLE, zero all counters, and drive out_valid, out_last, max_valid, busy and overrun to 0 and out_data, out_index, max_data and max_index to 0 on the next edge.
REQ-035 reset=1 mid-WAIT, CAPTURE or DRAIN SHALL abandon the job without emitting further words; the buffer contents need not be cleared.
REQ-036 mvm_done coincident with reset=1 SHALL be ignored.

Verification
REQ-037 K=32, LAT=2, mvm_done pulse, y[i]=i*3-40, out_ready=1 -> 32 words -40..53 with indices 0..31 in 32 consecutive cycles, out_last on 53, max 53 at index 31.
REQ-038 Same stream, out_ready toggled 1,0,1,0 -> identical word sequence, each word held stable during its ready=0 cycles.
REQ-039 y = all -5 except y[7]=y[20]=32767 -> max_data=32767, max_index=7, max_valid=1 in DRAIN.
REQ-040 Second mvm_done pulse during CAPTURE -> overrun=1 the next cycle, first job output unaffected, no second job started.
REQ-041 reset asserted at DRAIN word 10 -> out_valid=0 and all outputs 0 the next cycle; a new mvm_done then produces a clean 32-word job.
REQ-042 LAT=1 and LAT=4 builds -> y[0] captured exactly LAT cycles after the mvm_done cycle.
